seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Six-digit multiplexed scan controller for the board's common-anode seven-segment display. It sits directly upstream of the single-digit segment decoder. It holds a displayed 24-bit hex frame and rotates the 3-bit digit select. For each select it presents the matching nibble, decimal-point bit and blank flag to the decoder. New frames arrive over a valid/ready handshake and are applied only at frame boundaries, so a frame is never displayed half old and half new.

Parameters:
SCAN_DIV, 50000, clk cycles each digit is held (50 MHz / 50000 = 1 kHz per digit); legal range >= 2.
NUM_DIG, 6, number of digits; fixed at 6, not to be overridden.

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  asynchronous active-low reset.
en  input  1  scan enable; 0 freezes the scan and blanks the display.
in_valid  input  1  new frame offered.
in_ready  output  1  block can accept a frame.
in_data  input  24  six hex nibbles; nibble k = in_data[4k+3:4k] is shown on digit k.
in_dp  input  6  decimal point per digit, 1 = lit.
in_blank  input  6  blank per digit, 1 = digit off.
sel  output  3  current digit index, 0..5.
dig_data  output  4  nibble for current digit, to the decoder.
dig_dp  output  1  decimal point for current digit.
dig_blank  output  1  1 = decoder must drive all segments off.
frame_start  output  1  one-cycle pulse during the first cycle of each new frame.

Behaviour:
- Reset (asynchronous, immediate) sets:
  - prescaler cnt = 0, sel = 0
  - shadow data = 0, shadow dp = 0, shadow blank = 6'h3F (display dark)
  - pending buffer = 0, pending_full = 0, so in_ready = 1
  - frame_start = 0
- Prescaler:
  - cnt width = clog2(SCAN_DIV).
  - When en = 1, cnt increments each clk. tick = (cnt == SCAN_DIV-1) and en; on tick, cnt wraps to 0.
  - When en = 0, cnt is held at 0 and no tick occurs.
- Digit counter:
  - On tick, sel increments; 5 wraps to 0.
  - The tick where sel goes 5 -> 0 is the frame boundary (wrap).
- Outputs:
  - dig_data = shadow_data[4*sel+3 : 4*sel]; dig_dp = shadow_dp[sel].
  - dig_blank = shadow_blank[sel] OR ~en.
  - All are muxes driven only from registers, so they change in the same cycle sel changes.
- Handshake:
  - in_ready = ~pending_full.
  - Accept when in_valid && in_ready. On that edge, capture in_data/in_dp/in_blank into pending and set pending_full, so in_ready drops in the next cycle.
  - in_valid while in_ready = 0 is ignored; the source must hold it.
- Frame transfer:
  - On a wrap edge with pending_full = 1: copy pending into shadow and clear pending_full.
  - sel = 0 and the new shadow data appear in the same cycle; in_ready = 1 from the following cycle onward.
  - No accept can occur on the wrap edge itself (in_ready is 0 then).
  - If an accept and a wrap coincide while pending_full = 0, the data goes to pending and is applied at the next wrap, one full frame later.
- frame_start is registered: it is set by the wrap edge, so it is high exactly during the first sel = 0 cycle of each frame. It is 0 otherwise, including while en = 0.
- Pausing (en = 0):
  - sel is frozen and the display is blanked.
  - Handshake accepts still work (at most one pending frame), but no transfer happens while paused.
  - On return to en = 1, scanning resumes at the frozen sel with cnt = 0, so that digit is held a full SCAN_DIV cycles.
- Reset mid-frame discards the pending frame and the displayed frame.

Test Plan:
1. Bench uses SCAN_DIV = 4. Assert rst_n low with no clock -> sel=0, dig_blank=1, dig_dp=0, in_ready=1, frame_start=0. Release with en=1 -> digits stay blank (shadow blank = 3F).
2. en=1, no loads -> sel steps 0,1,2,3,4,5,0 with each value held 4 cycles; frame_start pulses once every 24 cycles, coincident with the first sel=0 cycle.
3. Mid-frame (sel=2), send in_data=24'hABC123, in_dp=6'b000001, in_blank=0 for one cycle -> in_ready=0 next cycle and outputs unchanged until wrap. At wrap: sel=0, dig_data=3, dig_dp=1. Then sel1=2, sel2=1, sel3=C, sel4=B, sel5=A, all with dig_blank=0. in_ready returns to 1 one cycle after the wrap.
4. Hold in_valid high with a second frame 24'h000042 while in_ready=0 -> not captured. It is accepted the cycle in_ready rises and is displayed starting at the next wrap (sel0 dig_data=2, sel1=4).
5. Drop en at sel=3 for 10 cycles while a frame is pending -> sel stays 3, dig_blank=1, no frame_start, pending kept. Raise en -> sel=3 held 4 cycles, then scan continues; pending applied at the next wrap.
6. Assert rst_n mid-frame with pending_full=1 -> all outputs return to reset values asynchronously. After release, the old pending frame is never displayed.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - six-digit multiplexed seven-segment scan controller
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int NUM_DIG  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  input  logic [5:0]  in_dp,
  input  logic [5:0]  in_blank,
  output logic [2:0]  sel,
  output logic [3:0]  dig_data,
  output logic        dig_dp,
  output logic        dig_blank,
  output logic        frame_start
);

  localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [2:0]    SEL_LAST = 3'(NUM_DIG - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic          wrap;
  logic          accept;
  logic          pending_full;
  logic [23:0]   shadow_data;
  logic [5:0]    shadow_dp;
  logic [5:0]    shadow_blank;
  logic [23:0]   pend_data;
  logic [5:0]    pend_dp;
  logic [5:0]    pend_blank;
  logic          blank_bit;

  assign tick     = en && (cnt == CNT_LAST);
  assign wrap     = tick && (sel == SEL_LAST);
  assign in_ready = ~pending_full;
  assign accept   = in_valid && ~pending_full;

  // Prescaler restarts from zero whenever scanning is paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel         <= 3'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        sel <= (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
      end
    end
  end

  // A pending frame only reaches the shadow registers on a frame wrap,
  // so the display never mixes two frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_full <= 1'b0;
      pend_data    <= '0;
      pend_dp      <= '0;
      pend_blank   <= '0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= 6'h3F;
    end else begin
      if (wrap && pending_full) begin
        shadow_data  <= pend_data;
        shadow_dp    <= pend_dp;
        shadow_blank <= pend_blank;
        pending_full <= 1'b0;
      end
      if (accept) begin
        pend_data    <= in_data;
        pend_dp      <= in_dp;
        pend_blank   <= in_blank;
        pending_full <= 1'b1;
      end
    end
  end

  always_comb begin
    dig_data  = 4'd0;
    dig_dp    = 1'b0;
    blank_bit = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (sel == 3'(k)) begin
        dig_data  = shadow_data[4*k +: 4];
        dig_dp    = shadow_dp[k];
        blank_bit = shadow_blank[k];
      end
    end
  end

  assign dig_blank = blank_bit | ~en;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int NUM_DIG  = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic [5:0]  in_dp = '0;
  logic [5:0]  in_blank = '0;
  logic [2:0]  sel;
  logic [3:0]  dig_data;
  logic        dig_dp;
  logic        dig_blank;
  logic        frame_start;
  bit          clk_on = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: which digit is lit, how long it has been lit, the frame on
  // screen and at most one frame waiting for the next frame boundary.
  int          m_sel;
  int          m_lit_cycles;
  bit          m_fs;
  bit          m_pfull;
  logic [23:0] m_sd, m_pd;
  logic [5:0]  m_sdp, m_sbl, m_pdp, m_pbl;

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .NUM_DIG(NUM_DIG)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dp(in_dp), .in_blank(in_blank), .sel(sel),
    .dig_data(dig_data), .dig_dp(dig_dp), .dig_blank(dig_blank),
    .frame_start(frame_start)
  );

  always #5 if (clk_on) clk = ~clk;

  task automatic model_reset();
    m_sel = 0; m_lit_cycles = 0; m_fs = 1'b0; m_pfull = 1'b0;
    m_sd = '0; m_sdp = '0; m_sbl = 6'h3F;
    m_pd = '0; m_pdp = '0; m_pbl = '0;
  endtask

  function automatic logic [10:0] model_out();
    return {3'(m_sel), m_sd[4*m_sel +: 4], m_sdp[m_sel], m_sbl[m_sel] | ~en, ~m_pfull, m_fs};
  endfunction

  function automatic logic [10:0] dut_out();
    return {sel, dig_data, dig_dp, dig_blank, in_ready, frame_start};
  endfunction

  // One clock: the model consumes the inputs present before the edge.
  task automatic step();
    bit take, adv, boundary;
    take     = in_valid && !m_pfull;
    adv      = en && (m_lit_cycles + 1 == SCAN_DIV);
    boundary = adv && (m_sel == NUM_DIG - 1);
    @(posedge clk);
    if (!en || adv) m_lit_cycles = 0;
    else m_lit_cycles++;
    if (adv) m_sel = (m_sel + 1) % NUM_DIG;
    m_fs = boundary;
    if (boundary && m_pfull) begin
      m_sd = m_pd; m_sdp = m_pdp; m_sbl = m_pbl; m_pfull = 1'b0;
    end
    if (take) begin
      m_pd = in_data; m_pdp = in_dp; m_pbl = in_blank; m_pfull = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if ({sel, dig_blank, dig_dp, in_ready, frame_start} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got sel=%0d blank=%b dp=%b rdy=%b fs=%b, want 0 1 0 1 0",
               sel, dig_blank, dig_dp, in_ready, frame_start);
    end
    #1 rst_n = 1'b1;
    en = 1'b1;
    clk_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if (dig_blank !== 1'b1 || dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL reset_dark: got %h want %h", dut_out(), model_out());
      end
    end
  endtask

  task automatic test_scan();
    int fs_seen;
    fs_seen = 0;
    en = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (frame_start === 1'b1) fs_seen++;
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL scan: got %h want %h", dut_out(), model_out());
      end
    end
    n_cmp++;
    if (fs_seen != 2) begin
      n_fail++;
      $display("FAIL scan_fs_count: got %0d want 2", fs_seen);
    end
  endtask

  task automatic test_load();
    logic [3:0] exp_nib [6];
    logic [3:0] seen [6];
    logic       any_blank;
    exp_nib = '{4'h3, 4'h2, 4'h1, 4'hC, 4'hB, 4'hA};
    any_blank = 1'b0;
    for (int i = 0; i < 40 && m_sel != 2; i++) step();
    n_cmp++;
    if (sel !== 3'd2) begin
      n_fail++;
      $display("FAIL load_wait_sel2: got %0d want 2", sel);
    end
    in_valid = 1'b1; in_data = 24'hABC123; in_dp = 6'b000001; in_blank = 6'b0;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || dut_out() !== model_out()) begin
      n_fail++;
      $display("FAIL load_ready_drop: got rdy=%b out=%h want rdy=0 out=%h", in_ready, dut_out(), model_out());
    end
    for (int i = 0; i < 40 && !m_fs; i++) begin
      step();
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL load_to_wrap: got %h want %h", dut_out(), model_out());
      end
    end
    n_cmp++;
    if ({frame_start, sel, dig_data, dig_dp, in_ready} !== {1'b1, 3'd0, 4'h3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL load_wrap: got fs=%b sel=%0d data=%h dp=%b rdy=%b want 1 0 3 1 1",
               frame_start, sel, dig_data, dig_dp, in_ready);
    end
    for (int i = 0; i < 24; i++) begin
      seen[sel] = dig_data;
      any_blank |= dig_blank;
      step();
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (seen[k] !== exp_nib[k]) begin
        n_fail++;
        $display("FAIL load_digit%0d: got %h want %h", k, seen[k], exp_nib[k]);
      end
    end
    n_cmp++;
    if (any_blank !== 1'b0) begin
      n_fail++;
      $display("FAIL load_unblanked: got blank seen=%b want 0", any_blank);
    end
  endtask

  task automatic test_hold_valid();
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1; in_data = 24'($urandom); in_dp = 6'($urandom); in_blank = 6'b0;
    step();
    in_data = 24'h000042; in_dp = 6'b0; in_blank = 6'b0;
    for (int i = 0; i < 60 && !accepted; i++) begin
      accepted = !m_pfull;
      step();
      if (accepted) in_valid = 1'b0;
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL hold_valid: got %h want %h", dut_out(), model_out());
      end
    end
    n_cmp++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL hold_accept_timeout: got no accept, want accept within 60 cycles");
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !m_fs; i++) step();
    n_cmp++;
    if ({frame_start, sel, dig_data} !== {1'b1, 3'd0, 4'h2}) begin
      n_fail++;
      $display("FAIL hold_sel0: got fs=%b sel=%0d data=%h want 1 0 2", frame_start, sel, dig_data);
    end
    for (int i = 0; i < SCAN_DIV; i++) step();
    n_cmp++;
    if ({sel, dig_data} !== {3'd1, 4'h4}) begin
      n_fail++;
      $display("FAIL hold_sel1: got sel=%0d data=%h want 1 4", sel, dig_data);
    end
  endtask

  task automatic test_pause();
    in_valid = 1'b1; in_data = 24'h987654; in_dp = 6'b100000; in_blank = 6'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && m_sel != 3; i++) step();
    n_cmp++;
    if (sel !== 3'd3 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_setup: got sel=%0d rdy=%b want 3 0", sel, in_ready);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({sel, dig_blank, frame_start, in_ready} !== {3'd3, 1'b1, 1'b0, 1'b0} ||
          dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL pause_frozen: got %h want %h", dut_out(), model_out());
      end
    end
    en = 1'b1;
    for (int i = 0; i < SCAN_DIV; i++) begin
      step();
      n_cmp++;
      if (sel !== ((i < SCAN_DIV - 1) ? 3'd3 : 3'd4) || dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL pause_resume: cycle %0d got %h want %h", i, dut_out(), model_out());
      end
    end
    for (int i = 0; i < 40 && !m_fs; i++) step();
    n_cmp++;
    if ({sel, dig_data, dig_dp, dig_blank} !== {3'd0, 4'h4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL pause_applied: got sel=%0d data=%h dp=%b blank=%b want 0 4 0 0",
               sel, dig_data, dig_dp, dig_blank);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 24'($urandom);
      in_dp    = 6'($urandom);
      in_blank = 6'($urandom);
      step();
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL random: cycle %0d got %h want %h", i, dut_out(), model_out());
      end
    end
    en = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    en = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 40 && m_pfull; i++) step();
    in_valid = 1'b1; in_data = 24'h5E5E5E; in_dp = 6'h3F; in_blank = 6'b0;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pending: got rdy=%b want 0", in_ready);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({sel, dig_blank, dig_dp, in_ready, frame_start} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0} ||
        dut_out() !== model_out()) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h want %h", dut_out(), model_out());
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      n_cmp++;
      if (dig_blank !== 1'b1 || dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL rstmid_stale: cycle %0d got %h want %h", i, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_hold_valid();
    test_pause();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
